// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the transmit and receive sides.
//   - bit positions of the 8-bit controls word
//   - baud select encodings and the divisor helper
//   - FSM state type
//   - data-bit mask helper
package uart_pkg;

  // controls[7:6] baud, [5] stop, [4] handshake, [3:2] data bits,
  // [1] even parity, [0] parity enable
  localparam int CTL_BAUD_HI = 7;
  localparam int CTL_BAUD_LO = 6;
  localparam int CTL_STOP    = 5;
  localparam int CTL_HS      = 4;
  localparam int CTL_BITS_HI = 3;
  localparam int CTL_BITS_LO = 2;
  localparam int CTL_EVEN    = 1;
  localparam int CTL_PAR_EN  = 0;

  typedef enum logic [1:0] {
    BAUD_7200   = 2'b00,
    BAUD_9600   = 2'b01,
    BAUD_19200  = 2'b10,
    BAUD_115200 = 2'b11
  } baud_sel_e;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } uart_state_e;

  // Counter terminal value: one bit period is (divisor + 1) clocks.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [1:0]  sel);
    int unsigned rate;
    case (sel)
      2'b00:   rate = 7200;
      2'b01:   rate = 9600;
      2'b10:   rate = 19200;
      default: rate = 115200;
    endcase
    return clk_freq / rate - 1;
  endfunction

  // Mask selecting the low 5..8 data bits for a data-bits field value.
  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    return 8'hFF >> (2'd3 - bits);
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Nios PIO side of the UART transmitter.
//   controls : 8-bit configuration word
//   data_in  : byte to queue, write : one-cycle push strobe
//   full     : FIFO full, busy : frame in flight or FIFO non-empty
// master = Nios/PIO side, slave = uart_tx_engine.
interface uart_tx_engine_if;
  logic [7:0] controls;
  logic [7:0] data_in;
  logic       write;
  logic       full;
  logic       busy;

  modport master (output controls, data_in, write, input full, busy);
  modport slave  (input controls, data_in, write, output full, busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter.
//   clk, rst  : clock, async active-low reset
//   write     : push wdata unless full (a write while full is dropped,
//               even when a pop happens in the same cycle)
//   pop       : remove head entry (ignored when empty)
//   full      : registered, reflects the count after the current edge
//   empty     : count == 0
//   head      : entry at the read pointer
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         write,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          push, do_pop;

  assign push   = write & ~full_q;
  assign do_pop = pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the wrap.
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage carries no reset; only entries behind the pointers are read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = full_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: bytes queued through a small FIFO are serialized on tx
// using a clock-enable baud counter on the system clock.
//   clk, rst     : system clock, async active-low reset
//   bus (slave)  : controls, data_in, write in; full, busy out
//   cts          : peer ready, only gates frame starts when handshake is on
//   send_break   : (UART_TX_BREAK_EN only) hold tx low while idle
//   tx           : serial output, idle high, registered
// Optional feature macro: UART_TX_BREAK_EN.
module uart_tx_engine #(
  parameter int CLK_FREQ   = 50000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_engine_if.slave bus,
  input  logic            cts,
`ifdef UART_TX_BREAK_EN
  input  logic            send_break,
`endif
  output logic            tx
);
  import uart_pkg::*;

  localparam int unsigned DIV_7200   = baud_div(CLK_FREQ, BAUD_7200);
  localparam int unsigned DIV_9600   = baud_div(CLK_FREQ, BAUD_9600);
  localparam int unsigned DIV_19200  = baud_div(CLK_FREQ, BAUD_19200);
  localparam int unsigned DIV_115200 = baud_div(CLK_FREQ, BAUD_115200);
  localparam int CNT_W = (DIV_7200 < 2) ? 1 : $clog2(DIV_7200 + 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       bits_q, bits_d;
  logic             stop2_q, stop2_d;
  logic             par_en_q, par_en_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;

  logic             fifo_full, fifo_empty, pop;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] div_sel;
  logic             head_par, start_ok, bit_done, load;
  logic [2:0]       last_bit;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .write (bus.write),
    .wdata (bus.data_in),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    case (baud_sel_e'(bus.controls[CTL_BAUD_HI:CTL_BAUD_LO]))
      BAUD_7200:  div_sel = CNT_W'(DIV_7200);
      BAUD_9600:  div_sel = CNT_W'(DIV_9600);
      BAUD_19200: div_sel = CNT_W'(DIV_19200);
      default:    div_sel = CNT_W'(DIV_115200);
    endcase
  end

  assign head_par = ^(fifo_head & data_mask(bus.controls[CTL_BITS_HI:CTL_BITS_LO]));
  assign bit_done = (baud_cnt_q == div_q);
  assign last_bit = 3'd4 + {1'b0, bits_q};

  // Break holds the start off; requiring tx_q high also guarantees at least
  // one idle-high cycle after a break before the next start bit.
`ifdef UART_TX_BREAK_EN
  assign start_ok = ~fifo_empty & (~bus.controls[CTL_HS] | cts) & ~send_break & tx_q;
`else
  assign start_ok = ~fifo_empty & (~bus.controls[CTL_HS] | cts);
`endif

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_done ? '0 : baud_cnt_q + 1'b1;
    div_d      = div_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    bits_d     = bits_q;
    stop2_d    = stop2_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (send_break) tx_d = 1'b0;
`endif
        load = start_ok;
      end
      START: if (bit_done) begin
        state_d   = DATA;
        tx_d      = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
      end
      DATA: if (bit_done) begin
        if (bit_cnt_q == last_bit) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d   = STOP;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      PARITY: if (bit_done) begin
        state_d   = STOP;
        tx_d      = 1'b1;
        bit_cnt_d = '0;
      end
      STOP: if (bit_done) begin
        // bit_cnt counts stop bits here; chain straight into the next start
        // so back-to-back frames carry no idle gap.
        if (bit_cnt_q == {2'b00, stop2_q}) begin
          if (start_ok) load = 1'b1;
          else          state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: controls are latched here so later changes wait a frame.
    if (load) begin
      pop        = 1'b1;
      state_d    = START;
      shift_d    = fifo_head;
      div_d      = div_sel;
      bits_d     = bus.controls[CTL_BITS_HI:CTL_BITS_LO];
      stop2_d    = bus.controls[CTL_STOP];
      par_en_d   = bus.controls[CTL_PAR_EN];
      par_d      = bus.controls[CTL_EVEN] ? head_par : ~head_par;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      tx_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      bits_q     <= '0;
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      bits_q     <= bits_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign bus.full = fifo_full;
  assign bus.busy = (state_q != IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine. The DUT runs with a reduced
// CLK_FREQ so every baud rate fits in a short run; the reference model
// derives the bit period from CLK_FREQ with the same integer division.
module tb_uart_tx_engine;
  localparam int CLK_FREQ = 5000000;
  localparam int DEPTH    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cts = 1'b1;
  logic tx;
`ifdef UART_TX_BREAK_EN
  logic send_break = 1'b0;
`endif

  uart_tx_engine_if bus();

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cts        (cts),
`ifdef UART_TX_BREAK_EN
    .send_break (send_break),
`endif
    .tx         (tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];   // expected tx level, one entry per clock
  int exp_p;      // bit period of the frames in exp_q

  // Reference frame: start, N data bits LSB first, optional parity, 1-2 stops.
  function automatic void add_frame(input logic [7:0] d, input logic [7:0] c);
    int rate, n;
    bit par;
    bit lvl[$];
    case (c[7:6])
      2'd0:    rate = 7200;
      2'd1:    rate = 9600;
      2'd2:    rate = 19200;
      default: rate = 115200;
    endcase
    exp_p = CLK_FREQ / rate;
    n = 5 + int'(c[3:2]);
    par = 1'b0;
    lvl.push_back(1'b0);
    for (int b = 0; b < n; b++) begin
      lvl.push_back(d[b]);
      par ^= d[b];
    end
    if (c[0]) lvl.push_back(c[1] ? par : ~par);
    lvl.push_back(1'b1);
    if (c[5]) lvl.push_back(1'b1);
    foreach (lvl[k]) repeat (exp_p) exp_q.push_back(lvl[k]);
  endfunction

  task automatic do_write(input logic [7:0] d);
    bus.data_in = d;
    bus.write   = 1'b1;
    @(posedge clk); #1;
    bus.write   = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: tx=%b busy=%b want tx=1 busy=0", tx, bus.busy);
    end
  endtask

  // 8N1 0x55, 7E1 0x07, 8-bit 2-stop 0xA3 at 7200.
  task automatic test_fixed_frames;
    logic [7:0] ctl [3] = '{8'hCC, 8'hCB, 8'h2C};
    logic [7:0] dat [3] = '{8'h55, 8'h07, 8'hA3};
    int bad;
    for (int t = 0; t < 3; t++) begin
      bus.controls = ctl[t];
      exp_q.delete();
      add_frame(dat[t], ctl[t]);
      do_write(dat[t]);
      @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL fixed%0d_prestart: tx=%b want 1", t, tx); end
      bad = 0;
      foreach (exp_q[i]) begin
        @(negedge clk);
        if (tx !== exp_q[i]) bad++;
        if ((i + 1) % exp_p == 0) begin
          checks++;
          if (bad != 0) begin errors++; $display("FAIL fixed%0d bit %0d: tx off on %0d cycles, want level %0b", t, i / exp_p, bad, exp_q[i]); end
          bad = 0;
        end
      end
      @(negedge clk);
      checks++; if (tx !== 1'b1 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL fixed%0d_end: tx=%b busy=%b want tx=1 busy=0", t, tx, bus.busy);
      end
    end
  endtask

  // Random formats; controls scrambled mid-frame must not affect the frame.
  task automatic test_random;
    logic [7:0] c, d;
    int bad;
    for (int t = 0; t < 4; t++) begin
      c = 8'($urandom) & 8'hEF;
      d = 8'($urandom);
      bus.controls = c;
      exp_q.delete();
      add_frame(d, c);
      do_write(d);
      @(negedge clk);
      bad = 0;
      foreach (exp_q[i]) begin
        @(negedge clk);
        if (i == 2 * exp_p) bus.controls = 8'($urandom);
        if (tx !== exp_q[i]) bad++;
        if ((i + 1) % exp_p == 0) begin
          checks++;
          if (bad != 0) begin errors++; $display("FAIL rand%0d ctl=%h dat=%h bit %0d: tx off on %0d cycles, want %0b", t, c, d, i / exp_p, bad, exp_q[i]); end
          bad = 0;
        end
      end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy: got %b want 0", t, bus.busy); end
    end
  endtask

  // 9 writes with cts held low: 8 fill the FIFO, the 9th is dropped.
  task automatic test_back_to_back;
    logic [7:0] d [9];
    int bad;
    cts = 1'b0;
    bus.controls = 8'hDC;
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin
      d[k] = 8'($urandom);
      if (k < DEPTH) add_frame(d[k], 8'hDC);
      do_write(d[k]);
      checks++; if (bus.full !== (k + 1 >= DEPTH)) begin
        errors++; $display("FAIL b2b_full after write %0d: got %b want %0b", k + 1, bus.full, (k + 1 >= DEPTH));
      end
    end
    cts = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_prestart: tx=%b want 1", tx); end
    bad = 0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL b2b_full_clear: got %b want 0", bus.full); end
      end
      if (tx !== exp_q[i]) bad++;
      if ((i + 1) % exp_p == 0) begin
        checks++;
        if (bad != 0) begin errors++; $display("FAIL b2b bit %0d: tx off on %0d cycles, want %0b", i / exp_p, bad, exp_q[i]); end
        bad = 0;
      end
    end
    @(negedge clk);
    checks++; if (tx !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end (9th byte must be dropped): tx=%b busy=%b want tx=1 busy=0", tx, bus.busy);
    end
  endtask

  task automatic test_handshake;
    int bad;
    cts = 1'b0;
    bus.controls = 8'hDC;
    exp_q.delete();
    add_frame(8'h41, 8'hDC);
    do_write(8'h41);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hs_hold: tx low on %0d cycles, want 0", bad); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hs_busy: got %b want 1", bus.busy); end
    @(posedge clk); #1;
    cts = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL hs_prestart: tx=%b want 1", tx); end
    bad = 0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (i == 3 * exp_p) cts = 1'b0;
      if (tx !== exp_q[i]) bad++;
      if ((i + 1) % exp_p == 0) begin
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hs bit %0d: tx off on %0d cycles, want %0b", i / exp_p, bad, exp_q[i]); end
        bad = 0;
      end
    end
    @(negedge clk);
    checks++; if (tx !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL hs_end: tx=%b busy=%b want tx=1 busy=0", tx, bus.busy);
    end
    cts = 1'b1;
  endtask

  // Reset during DATA with a full FIFO, then a clean frame afterwards.
  task automatic test_reset_midframe;
    logic [7:0] d;
    int bad;
    bus.controls = 8'hCC;
    do_write(8'($urandom) & 8'hF0);  // low bits zero so tx is low mid-DATA
    for (int k = 1; k < 9; k++) do_write(8'($urandom));
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL rstm_full_before: got %b want 1", bus.full); end
    repeat (3 * (CLK_FREQ / 115200)) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL rstm_tx: got %b want 1", tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstm_busy: got %b want 0", bus.busy); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rstm_full: got %b want 0", bus.full); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (tx !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstm_idle: tx=%b busy=%b want tx=1 busy=0", tx, bus.busy);
    end
    d = 8'($urandom);
    exp_q.delete();
    add_frame(d, 8'hCC);
    do_write(d);
    @(negedge clk);
    bad = 0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (tx !== exp_q[i]) bad++;
      if ((i + 1) % exp_p == 0) begin
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstm_frame bit %0d: tx off on %0d cycles, want %0b", i / exp_p, bad, exp_q[i]); end
        bad = 0;
      end
    end
  endtask

  initial begin
    bus.controls = 8'h00;
    bus.data_in  = 8'h00;
    bus.write    = 1'b0;
    test_reset();
    test_fixed_frames();
    test_random();
    test_back_to_back();
    test_handshake();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
